// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter for a shared DW-bit bus. The winning producer's payload is latched
// at grant and offered to a single consumer via a ready/accepted handshake. The owner gets a
// one-cycle done pulse on acceptance or an err pulse if the consumer never accepts in time.
module shared_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 64,
    parameter int TIMEOUT = 16
) (
    input  logic               clkArb,
    input  logic               rst,
    input  logic [NREQ-1:0]    reqIn,
    input  logic [NREQ*DW-1:0] dataIn,
    input  logic               acceptedIn,
    output logic [DW-1:0]      sharedBus64,
    output logic               readyOut,
    output logic [NREQ-1:0]    grantOut,
    output logic [NREQ-1:0]    doneOut,
    output logic [NREQ-1:0]    errOut
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Keep at least one timer bit when the timeout is disabled.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StDrive, StRelease} state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [TW-1:0]     timer;

    logic [PW-1:0]     sel;
    logic [NREQ-1:0]   sel_oh;
    logic [DW-1:0]     sel_data;
    int                best_d;
    logic              timed_out;

    // Distance of requester i from the slot right after the last grant.
    function automatic int rr_dist(input int i, input int p);
        return (i + NREQ - 1 - p) % NREQ;
    endfunction

    // Pick the requester closest (in round-robin order) to the last-grant pointer.
    always_comb begin
        best_d   = NREQ;
        sel      = '0;
        sel_oh   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (reqIn[i] && (rr_dist(i, int'(ptr)) < best_d)) begin
                best_d   = rr_dist(i, int'(ptr));
                sel      = PW'(i);
                sel_oh   = '0;
                sel_oh[i] = 1'b1;
                sel_data = dataIn[i*DW +: DW];
            end
        end
    end

    // Timeout fires on the last permitted DRIVE cycle; disabled when TIMEOUT is 0.
    always_comb begin
        timed_out = (TIMEOUT != 0) && (int'(timer) == TIMEOUT - 1);
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clkArb or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            ptr         <= PW'(NREQ - 1);
            timer       <= '0;
            sharedBus64 <= '0;
            readyOut    <= 1'b0;
            grantOut    <= '0;
            doneOut     <= '0;
            errOut      <= '0;
        end else begin
            case (state)
                StIdle: begin
                    doneOut <= '0;
                    errOut  <= '0;
                    if (reqIn != '0) begin
                        grantOut    <= sel_oh;
                        sharedBus64 <= sel_data;
                        readyOut    <= 1'b1;
                        timer       <= '0;
                        ptr         <= sel;
                        state       <= StDrive;
                    end
                end
                StDrive: begin
                    // Acceptance takes priority over a coincident timeout.
                    if (acceptedIn) begin
                        readyOut <= 1'b0;
                        doneOut  <= grantOut;
                        state    <= StRelease;
                    end else if (timed_out) begin
                        readyOut <= 1'b0;
                        errOut   <= grantOut;
                        state    <= StRelease;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                StRelease: begin
                    grantOut <= '0;
                    doneOut  <= '0;
                    errOut   <= '0;
                    state    <= StIdle;
                end
                default: begin
                    grantOut <= '0;
                    readyOut <= 1'b0;
                    doneOut  <= '0;
                    errOut   <= '0;
                    state    <= StIdle;
                end
            endcase
        end
    end

endmodule
